// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: the instruction-memory read port
// on one side and the instruction hand-off to the core on the other.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    // The fetch unit itself.
    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    // Memory plus core side that surrounds the fetch unit.
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers the
// returned words with their addresses in a small prefetch FIFO, and hands them
// to the core. A redirect flushes the buffer; a read already outstanding when
// the redirect arrives is waited out and its data thrown away (DROP state).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after;
    logic             push, pop, flush;
    logic             fifo_nonempty;
    logic [31:0]      redirect_pc_al;
    logic [63:0]      entry_rd [DEPTH];
    logic [63:0]      head;
    logic             unused_rpc_bits;

    // Redirect targets are forced word-aligned; the dropped bits are kept
    // visible here only so they are not mistaken for a wiring omission.
    assign redirect_pc_al  = {bus.redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^bus.redirect_pc[1:0];

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty & bus.instr_ready;

    // Next-state logic: fetch sequencing, redirect handling and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        push        = 1'b0;
        flush       = 1'b0;
        // FIFO count once this cycle's returned word is pushed and any pop is taken.
        count_after = count_q + CNT_W'(1) - CNT_W'(pop);

        unique case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_al;
                end else if (count_q < DEPTH_C) begin
                    state_d = S_FETCH;
                    addr_d  = fetch_pc_q;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    // Same-cycle ack: data is simply not pushed. Otherwise
                    // the request is still live and must be drained.
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_al;
                    state_d    = bus.imem_ack ? S_IDLE : S_DROP;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_after < DEPTH_C) begin
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // The FIFO is already empty here, so a redirect only retargets.
                if (bus.redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (bus.imem_ack) begin
                    state_d = S_FETCH;
                    addr_d  = bus.redirect ? redirect_pc_al : fetch_pc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d = (state_d != S_IDLE);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State, fetch address, request and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // One storage slot per FIFO entry, holding {instruction, address}.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [63:0] entry_q;

            // Capture the returned word when this slot is the write target.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_q <= {bus.imem_rdata, addr_q};
                end
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    assign head = entry_rd[rd_ptr_q];

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = fifo_nonempty;
    assign bus.instr       = fifo_nonempty ? head[63:32] : 32'h0;
    assign bus.instr_pc    = fifo_nonempty ? head[31:0]  : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal expectations
// plus a queue-based reference model checked on every cycle.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    instr_fetch_unit_if ifc();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word i holds i.
    assign ifc.imem_rdata = {2'b00, ifc.imem_addr[31:2]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Reference model: queue of buffered {instr, pc}, next program-order
    // address, and whether an outstanding read is to be discarded.
    logic [63:0] mq[$];
    logic [31:0] m_next_pc;
    bit          m_drop;
    bit          m_active = 0;
    bit          m_hold;
    logic [31:0] m_hold_addr;
    bit          m_pop;
    bit          m_acc;
    int          m_occ;

    // Per-cycle compare, then advance the model by the coming clock edge.
    always @(negedge clk) begin
        if (m_active) begin
            chk("instr_valid", {31'b0, ifc.instr_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("instr", ifc.instr, mq[0][63:32]);
                chk("instr_pc", ifc.instr_pc, mq[0][31:0]);
            end else begin
                chk("instr_empty", ifc.instr, 32'h0);
                chk("instr_pc_empty", ifc.instr_pc, 32'h0);
            end
            if (m_hold) begin
                chk("req_hold", {31'b0, ifc.imem_req}, 32'd1);
                chk("addr_hold", ifc.imem_addr, m_hold_addr);
            end
            if (ifc.imem_req && !m_drop) begin
                chk("addr_seq", ifc.imem_addr, m_next_pc);
            end
            m_occ = mq.size() + int'(ifc.imem_req);
            chk("occupancy_ok", {31'b0, m_occ <= DEPTH}, 32'd1);
        end

        if (reset) begin
            mq.delete();
            m_next_pc = 32'h0000_0000;
            m_drop    = 0;
            m_hold    = 0;
            m_active  = 1;
        end else if (m_active) begin
            m_pop = (mq.size() != 0) && ifc.instr_ready;
            m_acc = ifc.imem_req && ifc.imem_ack;
            if (ifc.redirect) begin
                mq.delete();
                if (ifc.imem_req && !ifc.imem_ack) m_drop = 1;
                else if (m_acc) m_drop = 0;
                m_next_pc = {ifc.redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pop) mq.delete(0);
                if (m_acc) begin
                    if (m_drop) begin
                        m_drop = 0;
                    end else begin
                        mq.push_back({mem_word(m_next_pc), m_next_pc});
                        m_next_pc = m_next_pc + 32'd4;
                    end
                end
            end
            m_hold      = ifc.imem_req && !ifc.imem_ack;
            m_hold_addr = ifc.imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for a few cycles, then check the first two post-reset cycles.
    // Returns at the sampling point of the first cycle with imem_req=1.
    task automatic do_reset(input logic a, input logic r);
        reset           = 1'b1;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'h0;
        ifc.imem_ack    = a;
        ifc.instr_ready = r;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req", {31'b0, ifc.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, ifc.instr_valid}, 32'd0);
        chk("rst_instr", ifc.instr, 32'h0);
        chk("rst_instr_pc", ifc.instr_pc, 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_req", {31'b0, ifc.imem_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("first_req", {31'b0, ifc.imem_req}, 32'd1);
        chk("first_addr", ifc.imem_addr, 32'h0000_0000);
    endtask

    initial begin
        reset           = 1'b1;
        ifc.imem_ack    = 1'b0;
        ifc.instr_ready = 1'b0;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = 32'h0;

        // Streaming: one instruction per cycle, pc 0,4,8,12.
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            $display("stream k=%0d valid=%0b pc=%h instr=%h", k, ifc.instr_valid, ifc.instr_pc, ifc.instr);
            chk("stream_valid", {31'b0, ifc.instr_valid}, 32'd1);
            chk("stream_pc", ifc.instr_pc, 32'(4 * k));
            chk("stream_instr", ifc.instr, 32'(k));
            chk("stream_req", {31'b0, ifc.imem_req}, 32'd1);
        end

        // Backpressure: exactly four words buffered, then no request until a pop.
        do_reset(1'b1, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("bp_last_addr", ifc.imem_addr, 32'h0000_000C);
        for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge clk);
            $display("backpressure j=%0d req=%0b pc=%h", j, ifc.imem_req, ifc.instr_pc);
            chk("bp_req_low", {31'b0, ifc.imem_req}, 32'd0);
            chk("bp_head_pc", ifc.instr_pc, 32'h0);
        end
        tick();
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_pc", ifc.instr_pc, 32'h0);
        chk("bp_pop_req", {31'b0, ifc.imem_req}, 32'd0);
        tick();
        ifc.instr_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_pop_pc", ifc.instr_pc, 32'h4);
        chk("bp_after_pop_req", {31'b0, ifc.imem_req}, 32'd0);
        tick();
        @(negedge clk);
        $display("backpressure refill req=%0b addr=%h", ifc.imem_req, ifc.imem_addr);
        chk("bp_refill_req", {31'b0, ifc.imem_req}, 32'd1);
        chk("bp_refill_addr", ifc.imem_addr, 32'h10);

        // Redirect while a request to 8 is held off.
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        ifc.imem_ack = 1'b0;
        @(negedge clk);
        chk("rd_wait_addr", ifc.imem_addr, 32'h8);
        tick();
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("rd_at_redirect_addr", ifc.imem_addr, 32'h8);
        tick();
        ifc.redirect = 1'b0;
        @(negedge clk);
        chk("drop_valid", {31'b0, ifc.instr_valid}, 32'd0);
        chk("drop_req", {31'b0, ifc.imem_req}, 32'd1);
        chk("drop_addr", ifc.imem_addr, 32'h8);
        tick();
        ifc.imem_ack = 1'b1;
        @(negedge clk);
        chk("drop_ack_valid", {31'b0, ifc.instr_valid}, 32'd0);
        tick();
        @(negedge clk);
        $display("after drop req=%0b addr=%h valid=%0b", ifc.imem_req, ifc.imem_addr, ifc.instr_valid);
        chk("refetch_addr", ifc.imem_addr, 32'h100);
        chk("refetch_valid", {31'b0, ifc.instr_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("refetch_pc", ifc.instr_pc, 32'h100);
        chk("refetch_instr", ifc.instr, 32'h40);

        // Redirect with a same-cycle ack, target at the top of the address space.
        tick();
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("sc_ack_addr", ifc.imem_addr, 32'h108);
        tick();
        ifc.redirect = 1'b0;
        @(negedge clk);
        chk("sc_valid", {31'b0, ifc.instr_valid}, 32'd0);
        chk("sc_req", {31'b0, ifc.imem_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("wrap_addr0", ifc.imem_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        $display("wrap addr=%h pc=%h instr=%h", ifc.imem_addr, ifc.instr_pc, ifc.instr);
        chk("wrap_addr1", ifc.imem_addr, 32'h0);
        chk("wrap_pc0", ifc.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", ifc.instr, 32'h3FFF_FFFF);
        tick();
        @(negedge clk);
        chk("wrap_pc1", ifc.instr_pc, 32'h0);

        // Reset while a request is being acked.
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_before", {31'b0, ifc.imem_req}, 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        $display("mid-fetch reset req=%0b valid=%0b", ifc.imem_req, ifc.instr_valid);
        chk("mid_rst_req", {31'b0, ifc.imem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, ifc.instr_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("mid_rst_refetch", ifc.imem_addr, 32'h0);
        tick();
        @(negedge clk);
        chk("mid_rst_pc", ifc.instr_pc, 32'h0);

        // Mixed ack/ready/redirect pattern checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            tick();
            ifc.imem_ack    = (i % 3) != 0;
            ifc.instr_ready = (i % 5) < 3;
            ifc.redirect    = (i == 17) || (i == 19) || (i == 40);
            ifc.redirect_pc = 32'h200 + 32'(i * 16);
        end
        tick();
        ifc.redirect = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
